// File: rtl/lcd_framebuffer.sv
// lcd_framebuffer: 4-bit colour-index framebuffer with registered read port, clear engine (FB_CLEAR_EN) and LCD refresh handshake
module lcd_framebuffer #(
    parameter int FB_W = 60,
    parameter int FB_H = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [5:0] wr_x,
    input  logic [5:0] wr_y,
    input  logic [3:0] wr_color,
    input  logic       clear_req,
    input  logic [3:0] clear_color,
    input  logic       flush_req,
    output logic       busy,
    input  logic [5:0] framebuffer_x_input,
    input  logic [5:0] framebuffer_y_input,
    output logic [3:0] framebuffer_frame,
    input  logic       lcd_ready,
    output logic       lcd_update
);
    localparam int N  = FB_W * FB_H;
    localparam int AW = $clog2(N);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_READY, UPDATE, WAIT_DROP} state_t;

    state_t          state;
    logic            pending;
    logic [3:0]      mem [N];
    logic            wr_ok, rd_ok;
    logic [AW-1:0]   wr_addr, rd_addr;

`ifdef FB_CLEAR_EN
    logic [AW-1:0]   clr_cnt;
    logic [3:0]      clr_color;
`else
    logic            unused_clear;
    assign unused_clear = ^{clear_req, clear_color};
`endif

    assign wr_ok   = wr_en && 32'(wr_x) < FB_W && 32'(wr_y) < FB_H && state != CLEAR;
    assign rd_ok   = 32'(framebuffer_x_input) < FB_W && 32'(framebuffer_y_input) < FB_H;
    assign wr_addr = AW'(32'(wr_y) * FB_W + 32'(wr_x));
    assign rd_addr = AW'(32'(framebuffer_y_input) * FB_W + 32'(framebuffer_x_input));
    assign busy    = state != IDLE || pending;

    // Control FSM: clear sequencing, flush merging and one-pulse-per-ready-window handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= 1'b0;
            lcd_update <= 1'b0;
`ifdef FB_CLEAR_EN
            clr_cnt    <= '0;
            clr_color  <= '0;
`endif
        end else begin
            if (flush_req && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: begin
`ifdef FB_CLEAR_EN
                    if (clear_req) begin
                        state     <= CLEAR;
                        clr_color <= clear_color;
                        clr_cnt   <= '0;
                        if (flush_req) pending <= 1'b1;
                    end else
`endif
                    if (flush_req || pending) begin
                        state   <= WAIT_READY;
                        pending <= 1'b0;
                    end
                end
`ifdef FB_CLEAR_EN
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(N - 1)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end
                end
`endif
                WAIT_READY: begin
                    if (lcd_ready) begin
                        state      <= UPDATE;
                        lcd_update <= 1'b1;
                    end
                end
                UPDATE: begin
                    state      <= WAIT_DROP;
                    lcd_update <= 1'b0;
                end
                WAIT_DROP: begin
                    if (!lcd_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage write port: the clear engine owns it while clearing, otherwise CPU writes
    always_ff @(posedge clk) begin
`ifdef FB_CLEAR_EN
        if (state == CLEAR) mem[clr_cnt] <= clr_color;
        else
`endif
        if (wr_ok) mem[wr_addr] <= wr_color;
    end

    // Registered read port; same-cycle write to the same address returns the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) framebuffer_frame <= 4'd0;
        else        framebuffer_frame <= rd_ok ? mem[rd_addr] : 4'd0;
    end
endmodule

// File: tb/tb_lcd_framebuffer.sv
// tb_lcd_framebuffer: randomized scoreboard bench for lcd_framebuffer (clear tests need FB_CLEAR_EN)
module tb_lcd_framebuffer;
    localparam int W = 60;
    localparam int H = 32;

    logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, clear_req = 1'b0, flush_req = 1'b0, lcd_ready = 1'b0;
    logic [5:0] wr_x = '0, wr_y = '0, rx = '0, ry = '0;
    logic [3:0] wr_color = '0, clear_color = '0;
    logic       busy, lcd_update;
    logic [3:0] frame;

    int checks = 0, errors = 0, pulses = 0;
    int model [H][W];
    int exp_q [$];
    bit rd_vld = 1'b0, clearing = 1'b0;

    always #5 clk = ~clk;

    lcd_framebuffer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .clear_req(clear_req), .clear_color(clear_color), .flush_req(flush_req), .busy(busy),
        .framebuffer_x_input(rx), .framebuffer_y_input(ry), .framebuffer_frame(frame),
        .lcd_ready(lcd_ready), .lcd_update(lcd_update)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pix(input int x, input int y);
        return (x < W && y < H) ? model[y][x] : 0;
    endfunction

    // Read monitor: a read presented at an edge is compared one edge later
    always begin
        bit v;
        int e;
        @(posedge clk);
        v = rd_vld;
        #1;
        if (v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read: got %0d expected <none, scoreboard empty>", frame);
            end else begin
                e = exp_q.pop_front();
                chk("read", int'(frame), e);
            end
        end
    end

    // Refresh pulse counter
    always begin
        @(posedge clk);
        #1;
        if (lcd_update) pulses++;
    end

    task automatic step(input bit we, input int x, input int y, input int c, input bit rd, input int qx, input int qy);
        wr_en = we; wr_x = x[5:0]; wr_y = y[5:0]; wr_color = c[3:0];
        rx = qx[5:0]; ry = qy[5:0]; rd_vld = rd;
        if (rd) exp_q.push_back(ref_pix(qx, qy));
        if (we && x < W && y < H && !clearing) model[y][x] = c;
        @(negedge clk);
        wr_en = 1'b0; rd_vld = 1'b0;
    endtask

    task automatic rnd_step();
        int x, y, qx, qy;
        x = $urandom_range(0, 63); y = $urandom_range(0, 40);
        qx = $urandom_range(0, 63); qy = $urandom_range(0, 40);
        if ($urandom_range(0, 3) == 0) begin qx = x; qy = y; end
        step($urandom_range(0, 1) == 1, x, y, $urandom_range(0, 15), 1'b1, qx, qy);
    endtask

    task automatic idle(input int n);
        repeat (n) rnd_step();
    endtask

    task automatic fill_model(input int c);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) model[y][x] = c;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_update", lcd_update, 0);
        chk("reset_frame", frame, 0);
        rst_n = 1'b1;

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) step(1'b1, x, y, $urandom_range(0, 15), 1'b0, 0, 0);

        step(1'b1, 5, 3, 9, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b1, 5, 3);
        step(1'b0, 0, 0, 0, 1'b1, 60, 3);
        step(1'b1, 60, 0, 15, 1'b1, 0, 1);
        step(1'b0, 0, 0, 0, 1'b1, 0, 1);
        step(1'b1, 7, 7, 4, 1'b1, 7, 7);
        step(1'b0, 0, 0, 0, 1'b1, 7, 7);
        idle(400);

        lcd_ready = 1'b0;
        p0 = pulses;
        flush_req = 1'b1; rnd_step(); flush_req = 1'b0;
        chk("flush_busy", busy, 1);
        idle(10);
        chk("flush_no_pulse", pulses - p0, 0);
        lcd_ready = 1'b1;
        rnd_step();
        chk("flush_update_hi", lcd_update, 1);
        rnd_step();
        chk("flush_update_lo", lcd_update, 0);
        idle(3);
        chk("flush_one_pulse", pulses - p0, 1);
        chk("flush_busy_drop", busy, 1);
        lcd_ready = 1'b0;
        idle(2);
        chk("flush_idle", busy, 0);

        p0 = pulses;
        lcd_ready = 1'b1;
        flush_req = 1'b1; rnd_step(); flush_req = 1'b0;
        idle(4);
        chk("merge_first", pulses - p0, 1);
        repeat (3) begin
            flush_req = 1'b1; rnd_step(); flush_req = 1'b0; rnd_step();
        end
        chk("merge_held", pulses - p0, 1);
        lcd_ready = 1'b0;
        idle(5);
        chk("merge_pending_busy", busy, 1);
        chk("merge_wait", pulses - p0, 1);
        lcd_ready = 1'b1;
        idle(4);
        lcd_ready = 1'b0;
        idle(3);
        chk("merge_total", pulses - p0, 2);
        chk("merge_idle", busy, 0);

        flush_req = 1'b1; rnd_step(); flush_req = 1'b0;
        idle(3);
        lcd_ready = 1'b1;
        rnd_step();
        chk("rst_upd_hi", lcd_update, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_upd_lo", lcd_update, 0);
        chk("rst_upd_busy", busy, 0);
        @(negedge clk);
        lcd_ready = 1'b0;
        rst_n = 1'b1;
        idle(20);

`ifdef FB_CLEAR_EN
        clear_req = 1'b1; clear_color = 4'd2;
        step(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clear_req = 1'b0;
        clearing = 1'b1;
        n = 0;
        while (busy && n < 3000) begin
            wr_en = (n == 960); wr_x = '0; wr_y = '0; wr_color = 4'd7;
            n++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        clearing = 1'b0;
        chk("clear_busy_cycles", n, W * H);
        fill_model(2);
        for (int a = 0; a < W * H; a++) step(1'b0, 0, 0, 0, 1'b1, a % W, a / W);

        p0 = pulses;
        lcd_ready = 1'b1;
        clear_req = 1'b1; flush_req = 1'b1; clear_color = 4'd3;
        step(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clear_req = 1'b0; flush_req = 1'b0;
        clearing = 1'b1;
        repeat (W * H - 1) @(negedge clk);
        chk("simul_no_early_pulse", pulses - p0, 0);
        chk("simul_busy", busy, 1);
        clearing = 1'b0;
        fill_model(3);
        repeat (5) @(negedge clk);
        chk("simul_one_pulse", pulses - p0, 1);
        lcd_ready = 1'b0;
        idle(3);
        chk("simul_idle", busy, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 0, 1'b1, $urandom_range(0, W - 1), $urandom_range(0, H - 1));
        step(1'b0, 0, 0, 0, 1'b1, W - 1, H - 1);

        clear_req = 1'b1; clear_color = 4'd5;
        step(1'b0, 0, 0, 0, 1'b0, 0, 0);
        clear_req = 1'b0;
        repeat (1000) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clear_busy", busy, 0);
        chk("rst_clear_update", lcd_update, 0);
        for (int a = 0; a < 1000; a++) model[a / W][a % W] = 5;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 990; a < 1010; a++) step(1'b0, 0, 0, 0, 1'b1, a % W, a / W);
        step(1'b0, 0, 0, 0, 1'b1, 0, 0);
        step(1'b0, 0, 0, 0, 1'b1, W - 1, H - 1);
`else
        clear_req = 1'b1; clear_color = 4'd6;
        rnd_step();
        clear_req = 1'b0;
        chk("clear_ignored_busy", busy, 0);
        idle(10);
        step(1'b0, 0, 0, 0, 1'b1, 0, 0);
        step(1'b0, 0, 0, 0, 1'b1, W - 1, H - 1);
`endif
        idle(200);
        step(1'b0, 0, 0, 0, 1'b0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_framebuffer.md
LCD_FRAMEBUFFER -- requirements
Module: lcd_framebuffer

Interface
REQ-001 SHALL have parameter FB_W, default 60, framebuffer columns.
REQ-002 SHALL have parameter FB_H, default 32, framebuffer rows.
REQ-003 SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  CPU pixel-write strobe, one write per cycle.
REQ-006 SHALL have port wr_x  input  6  write column.
REQ-007 SHALL have port wr_y  input  6  write row.
REQ-008 SHALL have port wr_color  input  4  write colour index, 0..15.
REQ-009 SHALL have port clear_req  input  1  single-cycle pulse that starts a fill of the whole buffer.
REQ-010 SHALL have port clear_color  input  4  fill colour, sampled in the cycle clear_req is accepted.
REQ-011 SHALL have port flush_req  input  1  single-cycle pulse requesting an LCD refresh.
REQ-012 SHALL have port busy  output  1  high while a clear or a refresh is pending or running.
REQ-013 SHALL have port framebuffer_x_input  input  6  LCD read column.
REQ-014 SHALL have port framebuffer_y_input  input  6  LCD read row.
REQ-015 SHALL have port framebuffer_frame  output  4  colour index at the read address.
REQ-016 SHALL have port lcd_ready  input  1  high when the LCD driver is idle.
REQ-017 SHALL have port lcd_update  output  1  one-cycle refresh pulse to the LCD driver.

Function
REQ-018 Storage SHALL be FB_W*FB_H entries of 4 bits, with address = y*FB_W + x (11 bits at the default size).
REQ-019 A write with wr_en=1, wr_x<FB_W and wr_y<FB_H in state IDLE, WAIT_READY or WAIT_DROP SHALL update the entry on the next edge.
REQ-020 A write that is out of range, or that arrives in state CLEAR, SHALL be dropped silently.
REQ-021 Read SHALL be registered: framebuffer_frame reflects the read address sampled on the previous edge, so latency is 1 cycle.
REQ-022 An out-of-range read address SHALL return 4'd0.
REQ-023 A write and a read to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-024 The FSM SHALL have exactly these states: IDLE, CLEAR, WAIT_READY, UPDATE, WAIT_DROP.
REQ-025 IDLE transitions: on clear_req go to CLEAR; else on flush_req or pending flag go to WAIT_READY.
REQ-026 If clear_req and flush_req arrive in the same cycle, clear SHALL win and the flush SHALL be latched as pending.
REQ-027 In CLEAR, one entry SHALL be written per cycle with clear_color, addresses 0..FB_W*FB_H-1 in order (1920 cycles at the default size); the FSM then returns to IDLE.
REQ-028 A flush_req during CLEAR SHALL set the pending flag; a flush_req during WAIT_READY, UPDATE or WAIT_DROP SHALL set the pending flag for one further refresh, with multiple requests merged into one.
REQ-029 A clear_req outside IDLE SHALL be ignored.
REQ-030 WAIT_READY SHALL hold until lcd_ready=1, then go to UPDATE; the pending flag SHALL clear on entry to WAIT_READY.
REQ-031 UPDATE SHALL drive lcd_update=1 for exactly one cycle, then go to WAIT_DROP.
REQ-032 WAIT_DROP SHALL hold until lcd_ready=0, then go to IDLE, so no second pulse can be issued to the same ready window.
REQ-033 busy SHALL be 1 whenever state != IDLE or the pending flag is set.
REQ-034 Pixel writes accepted during WAIT_READY, UPDATE or WAIT_DROP SHALL be readable immediately; tearing during a refresh is accepted behaviour.

Reset
REQ-035 When rst_n=0, the block SHALL enter IDLE asynchronously and drive lcd_update=0, busy=0, framebuffer_frame=0, pending=0, clear counter=0.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 A reset during CLEAR SHALL leave the buffer partially filled.
REQ-038 A reset during UPDATE SHALL end the lcd_update pulse immediately.
REQ-039 The block SHALL release from reset on the first clk edge after rst_n rises.

Configuration
REQ-040 Macro FB_CLEAR_EN SHALL control the clear engine.
REQ-041 With FB_CLEAR_EN defined, the CLEAR state and the clear counter SHALL be present as specified above.
REQ-042 Without FB_CLEAR_EN, clear_req and clear_color SHALL be ignored, state CLEAR SHALL be unreachable, and all other behaviour SHALL be unchanged.

Verification
REQ-043 Write: write (5,3)=4'd9, then read (5,3) -> framebuffer_frame=9 one cycle later; read (60,3) -> 0; write (60,0) -> no entry changes.
REQ-044 Clear: clear_req with clear_color=4'd2 -> busy=1 for 1920 cycles, then every address reads 2; a write issued mid-clear is lost.
REQ-045 Flush: hold lcd_ready=0, pulse flush_req, wait 10 cycles, then raise lcd_ready -> exactly one lcd_update pulse on the next cycle; then drop lcd_ready -> IDLE and busy=0.
REQ-046 Merge: pulse flush_req 3 times during WAIT_DROP -> exactly one extra lcd_update after the next ready rising edge.
REQ-047 Simultaneous: clear_req and flush_req in the same cycle -> the full clear completes first, then one lcd_update is issued.
REQ-048 Reset: assert rst_n=0 mid-clear at count 1000 -> busy=0 and lcd_update=0 asynchronously; addresses 0..999 keep the clear colour.
